// File: rtl/imem_loader.sv
// Byte-stream program loader for cpu_core: packs little-endian bytes into instruction words,
// writes them to imem, and gates the core enable around loading.
module imem_loader #(
  parameter int unsigned          NB_INSTRUCTION  = 32,
  parameter int unsigned          IMEM_ADDR_WIDTH = 5,
  parameter logic [NB_INSTRUCTION-1:0] END_WORD   = 32'hFFFF_FFFF,
  parameter logic [7:0]           CMD_LOAD        = 8'h4C,
  parameter logic [7:0]           CMD_RUN         = 8'h52,
  parameter logic [7:0]           CMD_HALT        = 8'h48
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic [NB_INSTRUCTION-1:0]  o_imem_data,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
  output logic                       o_imem_wen,
  output logic [1:0]                 o_mem_wsize,
  output logic                       o_cpu_en,
  output logic                       o_busy,
  output logic                       o_load_done,
  output logic                       o_err
);

  // state   | meaning
  // ST_IDLE | core stopped, waiting for 'L' or 'R'
  // ST_LOAD | core stopped, every byte is program data
  // ST_RUN  | core enabled, waiting for 'H' or 'L'
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  localparam int unsigned NB_SHIFT = NB_INSTRUCTION - 8;
  localparam logic [IMEM_ADDR_WIDTH-1:0] LAST_ADDR = {{(IMEM_ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [IMEM_ADDR_WIDTH-1:0] WORD_STEP = IMEM_ADDR_WIDTH'(4);

  state_t                       state_q, state_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic [NB_SHIFT-1:0]          shift_q, shift_d;
  logic [IMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                         full_q, full_d;
  logic                         wen_q, wen_d;
  logic [NB_INSTRUCTION-1:0]    data_q, data_d;
  logic [IMEM_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic [NB_INSTRUCTION-1:0]    word_c;

  assign word_c = {i_rx_data, shift_q};

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    full_d  = full_q;
    wen_d   = 1'b0;
    data_d  = data_q;
    waddr_d = waddr_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (i_rx_valid) begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (i_rx_data == CMD_LOAD) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            addr_d  = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
          end else if (state_q == ST_IDLE && i_rx_data == CMD_RUN) begin
            state_d = ST_RUN;
          end else if (state_q == ST_RUN && i_rx_data == CMD_HALT) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          cnt_d = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: shift_d[7:0]   = i_rx_data;
            2'd1: shift_d[15:8]  = i_rx_data;
            2'd2: shift_d[23:16] = i_rx_data;
            default: begin
              // End marker takes priority over overflow so a full memory can still close cleanly.
              if (word_c == END_WORD) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else if (full_q) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                wen_d   = 1'b1;
                data_d  = word_c;
                waddr_d = addr_q;
                addr_d  = addr_q + WORD_STEP;
                if (addr_q == LAST_ADDR) full_d = 1'b1;
              end
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_imem_data  = data_q;
  assign o_imem_waddr = waddr_q;
  assign o_imem_wen   = wen_q;
  assign o_mem_wsize  = 2'b10;
  assign o_cpu_en     = (state_q == ST_RUN);
  assign o_busy       = (state_q == ST_LOAD);
  assign o_load_done  = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed program loads plus random byte traffic,
// compared every cycle against a word-level reference model.
module tb_imem_loader;

  localparam int AW  = 5;
  localparam int CAP_WORDS = (1 << AW) / 4;
  localparam logic [31:0] END_W = 32'hFFFF_FFFF;
  localparam logic [7:0] C_L = 8'h4C, C_R = 8'h52, C_H = 8'h48;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [31:0]   imem_data;
  logic [AW-1:0] imem_waddr;
  logic          imem_wen;
  logic [1:0]    mem_wsize;
  logic          cpu_en, busy, load_done, err;

  imem_loader #(.NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_imem_data(imem_data), .o_imem_waddr(imem_waddr), .o_imem_wen(imem_wen),
    .o_mem_wsize(mem_wsize), .o_cpu_en(cpu_en), .o_busy(busy),
    .o_load_done(load_done), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0=stopped, 1=loading, 2=running
  int          m_mode;
  byte unsigned m_pend[$];
  int          m_words;
  logic        e_wen, e_done, e_err;
  logic [31:0] e_data;
  logic [AW-1:0] e_waddr;
  int          n_writes = 0;

  function automatic void model_reset();
    m_mode = 0; m_pend.delete(); m_words = 0;
    e_wen = 0; e_done = 0; e_err = 0; e_data = '0; e_waddr = '0;
  endfunction

  function automatic void model_byte(input logic v, input logic [7:0] d);
    logic [31:0] w;
    e_wen = 0; e_done = 0;
    if (!v) return;
    if (m_mode == 1) begin
      m_pend.push_back(d);
      if (m_pend.size() == 4) begin
        w = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
        m_pend.delete();
        if (w == END_W) begin
          e_done = 1; m_mode = 0;
        end else if (m_words >= CAP_WORDS) begin
          e_err = 1; m_mode = 0;
        end else begin
          e_wen = 1; e_data = w; e_waddr = AW'(m_words * 4); m_words++;
        end
      end
    end else if (d == C_L) begin
      m_mode = 1; m_pend.delete(); m_words = 0; e_err = 0;
    end else if (m_mode == 0 && d == C_R) m_mode = 2;
    else if (m_mode == 2 && d == C_H) m_mode = 0;
  endfunction

  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    rx_valid = v; rx_data = d; rst = r;
    @(posedge clk); #1;
    if (r) model_reset(); else model_byte(v, d);
    rx_valid = 0; rst = 0;
    if (e_wen) n_writes++;
    check_eq("wen",    imem_wen,   e_wen);
    check_eq("data",   imem_data,  e_data);
    check_eq("waddr",  imem_waddr, e_waddr);
    check_eq("cpu_en", cpu_en,     m_mode == 2);
    check_eq("busy",   busy,       m_mode == 1);
    check_eq("done",   load_done,  e_done);
    check_eq("err",    err,        e_err);
    check_eq("wsize",  mem_wsize,  2'b10);
    check_eq("no_en_during_wen", cpu_en & imem_wen, 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    tick(1, d, 0);
    if ($urandom_range(0, 2) == 0) tick(0, 8'h00, 0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  function automatic logic [7:0] non_cmd();
    logic [7:0] b;
    do b = 8'($urandom); while (b == C_L || b == C_R || b == C_H);
    return b;
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return C_L;
    if (r < 14) return C_R;
    if (r < 20) return C_H;
    if (r < 45) return 8'hFF;
    return 8'($urandom);
  endfunction

  initial begin
    model_reset();
    // reset wins over a simultaneous command byte
    tick(1, C_L, 1);
    tick(0, 8'h00, 0);

    // 1: single word then end marker
    send(C_L); send(8'h13); send(8'h05); send(8'h00); send(8'h00);
    send_word(END_W);
    tick(0, 8'h00, 0);

    // 2: three words, end, run, halt
    send(C_L);
    send_word(32'hDEAD_BEEF); send_word(32'h0011_2233); send_word(32'h8000_0001);
    send_word(END_W);
    send(C_R); tick(0, 8'h00, 0);
    send(C_H); tick(0, 8'h00, 0);

    // 3: overflow after capacity, next load clears err
    send(C_L);
    for (int i = 0; i <= CAP_WORDS; i++) send_word(32'h1000_0000 + 32'(i));
    tick(0, 8'h00, 0);
    send(C_L);
    send_word(END_W);

    // 4: reset drops a partial word
    send(C_L); send(8'hAA); send(8'hBB);
    tick(0, 8'h00, 1);
    send(C_L); send_word(32'hCAFE_F00D); send_word(END_W);

    // 5: load requested while running
    send(C_R); send(non_cmd());
    send(C_L); send_word(32'h0000_0ACE); send_word(END_W);

    // 6: non-command noise in IDLE and RUN, command values inside a word
    for (int i = 0; i < 20; i++) tick($urandom_range(0, 1) == 1, non_cmd(), 0);
    send(C_R);
    for (int i = 0; i < 20; i++) tick($urandom_range(0, 1) == 1, non_cmd(), 0);
    send(C_H);
    send(C_L); send_word({C_H, C_R, C_L, C_L}); send_word(END_W);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) tick(1, rand_byte(), 1);
      else if ($urandom_range(0, 59) == 0) send_word(END_W);
      else tick($urandom_range(0, 2) != 0, rand_byte(), 0);
    end

    if (n_writes < 12) begin
      n_cmp++; n_bad++;
      $display("FAIL write_coverage: got %0d writes expected at least 12", n_writes);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
